// File: rtl/square_root_if.sv
// Handshake/result bundle for the sequential square-root unit.
// The master drives start/A; the slave returns Q, busy and done.
interface square_root_if #(
  parameter int IN_W   = 12,
  parameter int FRAC_W = 6
);
  localparam int Q_W = IN_W/2 + FRAC_W;

  // Handshake: start is only honoured while busy is low. The accepting edge
  // latches A. busy stays high for the whole computation. done pulses for
  // exactly one cycle when Q is updated. done and busy are never high together.
  logic            start;
  logic [IN_W-1:0] A;
  logic [Q_W-1:0]  Q;
  logic            busy;
  logic            done;

  modport master (output start, A, input Q, busy, done);
  modport slave  (input start, A, output Q, busy, done);
endinterface

// File: rtl/square_root.sv
// Sequential fixed-point square root, Q = floor(sqrt(A * 2^(2*FRAC_W))), one root bit per clock.
// Optional macro SQRT_ROUND_EN rounds the result to nearest (saturating) instead of truncating.
module square_root #(
  parameter int IN_W   = 12,
  parameter int FRAC_W = 6
) (
  input  logic         clk,
  input  logic         rst_,
  square_root_if.slave bus,
  output logic         state_dbg
);
  localparam int Q_W   = IN_W/2 + FRAC_W;
  localparam int X_W   = 2*Q_W;
  localparam int CNT_W = (Q_W > 1) ? $clog2(Q_W) : 1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t         state;
  logic [X_W-1:0] x;
  logic [Q_W-1:0] root;
  logic [Q_W+1:0] rem;
  logic [CNT_W-1:0] cnt;

  logic [Q_W+1:0] rem_shift;
  logic [Q_W+1:0] trial;
  logic [Q_W+1:0] rem_sub;
  logic           fit;
  logic [Q_W-1:0] root_next;
  logic [Q_W+1:0] rem_next;
  logic [Q_W-1:0] q_final;

  // The top two remainder bits are zero before every non-final step; folding
  // them into the compare keeps the arithmetic correct for the full register.
  always_comb begin
    rem_shift = {rem[Q_W-1:0], x[X_W-1 -: 2]};
    trial     = {root, 2'b01};
    rem_sub   = rem_shift - trial;
    fit       = (rem[Q_W+1:Q_W] != 2'b00) || (rem_shift >= trial);
    root_next = {root[Q_W-2:0], fit};
    rem_next  = fit ? rem_sub : rem_shift;
  end

`ifdef SQRT_ROUND_EN
  always_comb begin
    q_final = root_next;
    if ((rem_next > {2'b00, root_next}) && (root_next != {Q_W{1'b1}}))
      q_final = root_next + {{(Q_W-1){1'b0}}, 1'b1};
  end
`else
  always_comb begin
    q_final = root_next;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst_) begin
      state    <= IDLE;
      x        <= '0;
      root     <= '0;
      rem      <= '0;
      cnt      <= '0;
      bus.Q    <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            x        <= {bus.A, {(2*FRAC_W){1'b0}}};
            root     <= '0;
            rem      <= '0;
            cnt      <= CNT_W'(Q_W-1);
            bus.busy <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          x    <= {x[X_W-3:0], 2'b00};
          root <= root_next;
          rem  <= rem_next;
          cnt  <= cnt - 1'b1;
          if (cnt == '0) begin
            bus.Q    <= q_final;
            bus.done <= 1'b1;
            bus.busy <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign state_dbg = (state == RUN);
endmodule

// File: tb/tb_square_root.sv
// Directed and random bench for square_root with an expected-result queue.
`timescale 1ns/1ps
module tb_square_root;
  localparam int IN_W   = 12;
  localparam int FRAC_W = 6;
  localparam int Q_W    = IN_W/2 + FRAC_W;

  logic clk = 1'b0;
  logic rst_ = 1'b1;
  logic state_dbg;

  square_root_if #(.IN_W(IN_W), .FRAC_W(FRAC_W)) bus ();

  square_root #(.IN_W(IN_W), .FRAC_W(FRAC_W)) dut (
    .clk       (clk),
    .rst_      (rst_),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  logic [Q_W-1:0] exp_q[$];
  logic [Q_W-1:0] exp_v;
  int tests    = 0;
  int failed   = 0;
  int done_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: build the root bit by bit by squaring candidates.
  function automatic logic [Q_W-1:0] model(input logic [IN_W-1:0] a);
    longint x, q, t, r;
    x = longint'(a) << (2*FRAC_W);
    q = 0;
    for (int b = Q_W-1; b >= 0; b--) begin
      t = q | (longint'(1) << b);
      if (t*t <= x) q = t;
    end
`ifdef SQRT_ROUND_EN
    r = x - q*q;
    if (r > q && q < ((longint'(1) << Q_W) - 1)) q = q + 1;
`else
    r = 0;
`endif
    return q[Q_W-1:0];
  endfunction

  // Scoreboard: every done pops one expected root.
  always @(posedge clk) begin
    #1;
    if (!rst_ && bus.done) begin
      done_cnt++;
      check("done_busy_overlap", {31'b0, bus.busy}, 32'd0);
      if (exp_q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
      else begin
        exp_v = exp_q.pop_front();
        check("q_value", {20'b0, bus.Q}, {20'b0, exp_v});
      end
    end
  end

  task automatic do_op(input logic [IN_W-1:0] a, input logic [Q_W-1:0] exp, input string tag);
    int n;
    @(negedge clk);
    bus.A = a;
    bus.start = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.A = IN_W'($urandom_range(0, (1 << IN_W) - 1));
    check({tag, "_busy"}, {31'b0, bus.busy}, 32'd1);
    n = 0;
    while (n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.done) break;
    end
    check({tag, "_latency"}, n, Q_W);
  endtask

  initial begin
    int n, gap, cnt0;
    logic [IN_W-1:0] a;
    bus.start = 1'b0;
    bus.A = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_q", {20'b0, bus.Q}, 32'd0);
    check("reset_busy", {31'b0, bus.busy}, 32'd0);
    check("reset_done", {31'b0, bus.done}, 32'd0);
    check("reset_state", {31'b0, state_dbg}, 32'd0);
    @(negedge clk);
    rst_ = 1'b0;

    do_op(12'd256, 12'd1024, "a256");
`ifdef SQRT_ROUND_EN
    do_op(12'd2, 12'd91, "a2");
`else
    do_op(12'd2, 12'd90, "a2");
`endif
    do_op(12'd0, 12'd0, "a0");
    do_op(12'd4095, 12'd4095, "a4095");
    for (int i = 0; i < 6; i++) begin
      a = IN_W'($urandom_range(0, (1 << IN_W) - 1));
      do_op(a, model(a), "rand");
    end

    // start held high; A changes to 1 in the middle of the first run
    @(negedge clk);
    bus.A = 12'd256;
    bus.start = 1'b1;
    exp_q.push_back(12'd1024);
    exp_q.push_back(12'd64);
    @(posedge clk);
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus.A = 12'd1;
    n = 0;
    while (n < 40 && !bus.done) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("held_first_done", {31'b0, bus.done}, 32'd1);
    gap = 0;
    do begin
      @(posedge clk);
      #1;
      gap++;
    end while (!bus.done && gap < 40);
    bus.start = 1'b0;
    check("held_gap", gap, Q_W + 1);
    repeat (2) @(posedge clk);
    #1;
    check("held_idle", {31'b0, bus.busy}, 32'd0);

    // reset in the 5th RUN cycle aborts the operation
    cnt0 = done_cnt;
    @(negedge clk);
    bus.A = 12'd2000;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_ = 1'b1;
    @(negedge clk);
    rst_ = 1'b0;
    check("abort_q", {20'b0, bus.Q}, 32'd0);
    check("abort_busy", {31'b0, bus.busy}, 32'd0);
    check("abort_state", {31'b0, state_dbg}, 32'd0);
    repeat (20) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt, cnt0);
    do_op(12'd1, 12'd64, "after_abort");

    // start pulsed while busy is ignored
    cnt0 = done_cnt;
    @(negedge clk);
    bus.A = 12'd100;
    bus.start = 1'b1;
    exp_q.push_back(model(12'd100));
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus.A = 12'd4095;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("busy_start_one_done", done_cnt - cnt0, 32'd1);
    check("model_a100", {20'b0, model(12'd100)}, 32'd640);

    check("queue_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
